// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: PC select codes, branch condition codes,
// IR field positions and register-select one-hot codes.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEL_INC  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_DP   = 2'b10;
    localparam logic [1:0] PC_SEL_HOLD = 2'b11;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    localparam int IR_OPCODE_HI = 15;
    localparam int IR_OPCODE_LO = 13;
    localparam int IR_OP_HI     = 12;
    localparam int IR_OP_LO     = 11;
    localparam int IR_RN_HI     = 10;
    localparam int IR_RN_LO     = 8;
    localparam int IR_RD_HI     = 7;
    localparam int IR_RD_LO     = 5;
    localparam int IR_SH_HI     = 4;
    localparam int IR_SH_LO     = 3;
    localparam int IR_RM_HI     = 2;
    localparam int IR_RM_LO     = 0;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam int STATUS_N = 2;
    localparam int STATUS_V = 1;
    localparam int STATUS_Z = 0;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_branch_cond.sv
// Branch condition evaluator: decides whether a pc_sel=branch load is taken
// given the IR condition field and the {N,V,Z} status flags.
module branch_cond
    import fetch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] status,
    input  logic       cond_br,
    output logic       take
);

    logic n_s;
    logic v_s;
    logic z_s;
    logic cond_true_s;

    assign n_s = status[STATUS_N];
    assign v_s = status[STATUS_V];
    assign z_s = status[STATUS_Z];

    // Condition table; unconditional branches ignore the flags entirely
    always_comb begin
        cond_true_s = 1'b0;
        case (cond)
            COND_AL: cond_true_s = 1'b1;
            COND_EQ: cond_true_s = z_s;
            COND_NE: cond_true_s = ~z_s;
            COND_LT: cond_true_s = n_s ^ v_s;
            COND_LE: cond_true_s = (n_s ^ v_s) | z_s;
            default: cond_true_s = 1'b0;
        endcase
        if (cond_br) begin
            take = cond_true_s;
        end else begin
            take = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / address generation: PC, IR and data address registers,
// IR field decode, branch resolution and a retired-instruction counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          PC_W     = 9,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_ir,
    input  logic             load_pc,
    input  logic             reset_pc,
    input  logic             addr_sel,
    input  logic             load_addr,
    input  logic [1:0]       pc_sel,
    input  logic             cond_br,
    input  logic [2:0]       nsel,
    input  logic             halt,
    input  logic [15:0]      mem_rdata,
    input  logic [15:0]      datapath_out,
    input  logic [2:0]       status,
    output logic [15:0]      ir,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [2:0]       reg_num,
    output logic [1:0]       sh,
    output logic [15:0]      sximm5,
    output logic [15:0]      sximm8,
    output logic [2:0]       cond,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  mem_addr,
    output logic             branch_taken,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    logic [PC_W-1:0]  pc_q,   pc_d;
    logic [15:0]      ir_q,   ir_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             bt_q,   bt_d;

    logic [PC_W-1:0]  pc_inc_s;
    logic [PC_W-1:0]  br_target_s;
    logic             take_s;
    logic             unused_s;

    assign unused_s = ^datapath_out[15:PC_W];

    assign opcode = ir_q[IR_OPCODE_HI:IR_OPCODE_LO];
    assign op     = ir_q[IR_OP_HI:IR_OP_LO];
    assign cond   = ir_q[IR_RN_HI:IR_RN_LO];
    assign sh     = ir_q[IR_SH_HI:IR_SH_LO];
    assign sximm5 = sext5(ir_q[4:0]);
    assign sximm8 = sext8(ir_q[7:0]);

    assign ir           = ir_q;
    assign pc           = pc_q;
    assign instr_count  = cnt_q;
    assign branch_taken = bt_q;
    assign mem_addr     = addr_sel ? pc_q : addr_q;

    // The PC already points past the branch when it executes, so the offset is applied to pc_q
    assign pc_inc_s    = pc_q + PC_W'(1);
    assign br_target_s = pc_q + sximm8[PC_W-1:0];

    branch_cond u_branch_cond (
        .cond    (ir_q[IR_RN_HI:IR_RN_LO]),
        .status  (status),
        .cond_br (cond_br),
        .take    (take_s)
    );

    // Register-number select with Rn > Rd > Rm priority
    always_comb begin
        reg_num = 3'b000;
        if ((nsel & NSEL_RN) != 3'b000) begin
            reg_num = ir_q[IR_RN_HI:IR_RN_LO];
        end else if ((nsel & NSEL_RD) != 3'b000) begin
            reg_num = ir_q[IR_RD_HI:IR_RD_LO];
        end else if ((nsel & NSEL_RM) != 3'b000) begin
            reg_num = ir_q[IR_RM_HI:IR_RM_LO];
        end else begin
            reg_num = 3'b000;
        end
    end

    // Next-state logic: halt freezes everything, reset_pc outranks load_pc
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        bt_d   = 1'b0;
        if (halt) begin
            bt_d = 1'b0;
        end else begin
            if (reset_pc) begin
                pc_d = RESET_PC_V;
            end else if (load_pc) begin
                case (pc_sel)
                    PC_SEL_INC: pc_d = pc_inc_s;
                    PC_SEL_BR: begin
                        if (take_s) begin
                            pc_d = br_target_s;
                            bt_d = 1'b1;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end
                    PC_SEL_DP:   pc_d = datapath_out[PC_W-1:0];
                    PC_SEL_HOLD: pc_d = pc_q;
                    default:     pc_d = pc_q;
                endcase
            end else begin
                pc_d = pc_q;
            end
            if (load_ir) begin
                ir_d  = mem_rdata;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ir_d  = ir_q;
                cnt_d = cnt_q;
            end
            if (load_addr) begin
                addr_d = datapath_out[PC_W-1:0];
            end else begin
                addr_d = addr_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_PC_V;
            ir_q   <= 16'h0000;
            addr_q <= '0;
            cnt_q  <= '0;
            bt_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            bt_q   <= bt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random stimulus,
// all checked against an arithmetic reference model.
module tb_fetch_unit;

    localparam int PC_W  = 9;
    localparam int CNT_W = 16;
    localparam int PC_MOD  = 512;
    localparam int CNT_MOD = 65536;

    logic             clk;
    logic             reset_n;
    logic             load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0]       pc_sel;
    logic             cond_br;
    logic [2:0]       nsel;
    logic             halt;
    logic [15:0]      mem_rdata, datapath_out;
    logic [2:0]       status;
    logic [15:0]      ir;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [2:0]       reg_num;
    logic [1:0]       sh;
    logic [15:0]      sximm5, sximm8;
    logic [2:0]       cond;
    logic [PC_W-1:0]  pc, mem_addr;
    logic             branch_taken;
    logic [CNT_W-1:0] instr_count;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
        .pc_sel(pc_sel), .cond_br(cond_br), .nsel(nsel), .halt(halt),
        .mem_rdata(mem_rdata), .datapath_out(datapath_out), .status(status),
        .ir(ir), .opcode(opcode), .op(op), .reg_num(reg_num), .sh(sh),
        .sximm5(sximm5), .sximm8(sximm8), .cond(cond), .pc(pc),
        .mem_addr(mem_addr), .branch_taken(branch_taken), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       pc;
        int       ir;
        int       addr;
        int       cnt;
        bit       bt;
        bit       asel;
        bit [2:0] nsel;
    } exp_t;
    exp_t sb[$];

    int m_pc, m_ir, m_addr, m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input int c, input int st);
        int n, v, z;
        n = (st >> 2) & 1;
        v = (st >> 1) & 1;
        z = st & 1;
        case (c)
            0: return 1'b1;
            1: return z == 1;
            2: return z == 0;
            3: return n != v;
            4: return (n != v) || (z == 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sext(input int val, input int bits);
        int v;
        v = val & ((1 << bits) - 1);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return v;
    endfunction

    task automatic idle();
        load_ir = 1'b0; load_pc = 1'b0; reset_pc = 1'b0; addr_sel = 1'b1;
        load_addr = 1'b0; pc_sel = 2'b00; cond_br = 1'b0; nsel = 3'b000;
        halt = 1'b0; mem_rdata = 16'h0000; datapath_out = 16'h0000; status = 3'b000;
    endtask

    // Apply model for the current inputs, queue expectation, advance one cycle
    task automatic step();
        int npc;
        bit nbt;
        npc = m_pc;
        nbt = 1'b0;
        if (!halt) begin
            if (reset_pc) begin
                npc = 0;
            end else if (load_pc) begin
                case (int'(pc_sel))
                    0: npc = (m_pc + 1) % PC_MOD;
                    1: begin
                        if (!cond_br || cond_holds((m_ir >> 8) & 7, int'(status))) begin
                            npc = (m_pc + sext(m_ir, 8) + PC_MOD) % PC_MOD;
                            nbt = 1'b1;
                        end else begin
                            npc = (m_pc + 1) % PC_MOD;
                        end
                    end
                    2: npc = int'(datapath_out) % PC_MOD;
                    default: npc = m_pc;
                endcase
            end
            if (load_ir) begin
                m_ir  = int'(mem_rdata);
                m_cnt = (m_cnt + 1) % CNT_MOD;
            end
            if (load_addr) m_addr = int'(datapath_out) % PC_MOD;
        end
        m_pc = npc;
        sb.push_back('{pc: m_pc, ir: m_ir, addr: m_addr, cnt: m_cnt, bt: nbt,
                       asel: addr_sel, nsel: nsel});
        @(negedge clk);
    endtask

    task automatic set_pc_and_ir(input logic [15:0] dp, input logic [15:0] instr);
        idle(); load_pc = 1'b1; pc_sel = 2'b10; datapath_out = dp;
        load_ir = 1'b1; mem_rdata = instr; step();
    endtask

    task automatic branch(input logic [15:0] instr, input logic [2:0] st, input logic cb);
        set_pc_and_ir(16'h0008, instr);
        idle(); load_pc = 1'b1; pc_sel = 2'b01; status = st; cond_br = cb; nsel = 3'b100; step();
        idle(); step();
    endtask

    // Monitor: compare every output against the queued expectation after each edge
    always @(posedge clk) begin
        exp_t e;
        int rn;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", int'(pc), e.pc);
            check("ir", int'(ir), e.ir);
            check("instr_count", int'(instr_count), e.cnt);
            check("branch_taken", int'(branch_taken), int'(e.bt));
            check("mem_addr", int'(mem_addr), e.asel ? e.pc : e.addr);
            check("opcode", int'(opcode), (e.ir >> 13) & 7);
            check("op", int'(op), (e.ir >> 11) & 3);
            check("cond", int'(cond), (e.ir >> 8) & 7);
            check("sh", int'(sh), (e.ir >> 3) & 3);
            check("sximm5", int'(sximm5), sext(e.ir, 5) & 16'hFFFF);
            check("sximm8", int'(sximm8), sext(e.ir, 8) & 16'hFFFF);
            if (e.nsel[2])      rn = (e.ir >> 8) & 7;
            else if (e.nsel[1]) rn = (e.ir >> 5) & 7;
            else if (e.nsel[0]) rn = e.ir & 7;
            else                rn = 0;
            check("reg_num", int'(reg_num), rn);
        end
    end

    initial begin
        int guard;
        idle();
        reset_n = 1'b0;
        m_pc = 0; m_ir = 0; m_addr = 0; m_cnt = 0;
        #3;
        check("rst_pc", int'(pc), 0);
        check("rst_ir", int'(ir), 0);
        check("rst_cnt", int'(instr_count), 0);
        check("rst_bt", int'(branch_taken), 0);
        check("rst_sximm8", int'(sximm8), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fetch
        idle(); load_ir = 1'b1; mem_rdata = 16'hD105; nsel = 3'b010; step();
        idle(); load_pc = 1'b1; pc_sel = 2'b00; nsel = 3'b001; step();

        // BEQ taken / not taken, BLT, BLE, never-taken, unconditional
        branch(16'h21FC, 3'b001, 1'b1);
        branch(16'h21FC, 3'b000, 1'b1);
        branch(16'h2302, 3'b100, 1'b1);
        branch(16'h2403, 3'b111, 1'b1);
        branch(16'h2505, 3'b001, 1'b1);
        branch(16'h2505, 3'b000, 1'b0);
        branch(16'h2280, 3'b001, 1'b1);

        // BX then increment wrap
        idle(); load_pc = 1'b1; pc_sel = 2'b10; datapath_out = 16'h01FF; step();
        idle(); load_pc = 1'b1; pc_sel = 2'b00; step();

        // Data address path and reset_pc priority
        idle(); load_addr = 1'b1; datapath_out = 16'h0042; addr_sel = 1'b0; step();
        idle(); addr_sel = 1'b0; step();
        idle(); addr_sel = 1'b1; load_pc = 1'b1; pc_sel = 2'b10; datapath_out = 16'h0077; step();
        idle(); reset_pc = 1'b1; load_pc = 1'b1; pc_sel = 2'b10; datapath_out = 16'h0055; step();

        // Halt with every load asserted
        set_pc_and_ir(16'h0010, 16'h20F0);
        idle(); halt = 1'b1; load_ir = 1'b1; load_pc = 1'b1; reset_pc = 1'b1;
        load_addr = 1'b1; pc_sel = 2'b01; mem_rdata = 16'hFFFF; datapath_out = 16'h0123; step();
        step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            load_ir      = 1'($urandom_range(0, 1));
            load_pc      = 1'($urandom_range(0, 1));
            reset_pc     = ($urandom_range(0, 15) == 0);
            halt         = ($urandom_range(0, 7) == 0);
            addr_sel     = 1'($urandom_range(0, 1));
            load_addr    = 1'($urandom_range(0, 1));
            pc_sel       = 2'($urandom_range(0, 3));
            cond_br      = 1'($urandom_range(0, 1));
            nsel         = 3'($urandom_range(0, 7));
            mem_rdata    = 16'($urandom);
            datapath_out = 16'($urandom);
            status       = 3'($urandom_range(0, 7));
            step();
        end

        // Asynchronous reset in the middle of a cycle with loads pending
        set_pc_and_ir(16'h0033, 16'hD1A5);
        idle(); load_ir = 1'b1; load_pc = 1'b1; mem_rdata = 16'h1234;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_pc", int'(pc), 0);
        check("mid_rst_ir", int'(ir), 0);
        check("mid_rst_cnt", int'(instr_count), 0);
        check("mid_rst_opcode", int'(opcode), 0);
        check("mid_rst_mem_addr", int'(mem_addr), 0);
        check("mid_rst_bt", int'(branch_taken), 0);
        m_pc = 0; m_ir = 0; m_addr = 0; m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        idle(); load_ir = 1'b1; mem_rdata = 16'hD105; step();
        idle(); load_pc = 1'b1; step();

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and address-generation stage driven by the control state machine.
- Holds the program counter (PC), the instruction register (IR) and the data address register.
- Drives the memory address, decodes IR fields for the controller and datapath, and evaluates conditional branches against datapath status.
- Also keeps a retired-instruction counter for debug and bench checking.

Parameters:
- PC_W, 9, width of PC, data address register and mem_addr
- RESET_PC, 0, PC value loaded on reset_n or reset_pc
- CNT_W, 16, width of instr_count

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; the only clock and reset of the block
- load_ir  in  1  capture mem_rdata into IR
- load_pc  in  1  update PC per pc_sel
- reset_pc  in  1  synchronous PC reload to RESET_PC
- addr_sel  in  1  1: mem_addr=PC; 0: mem_addr=data address register
- load_addr  in  1  capture datapath_out[PC_W-1:0] into data address register
- pc_sel  in  2  00 PC+1; 01 branch target; 10 datapath_out[PC_W-1:0] (BX/BLX); 11 hold
- cond_br  in  1  with pc_sel=01: take branch only if cond true
- nsel  in  3  one-hot register select {Rn,Rd,Rm}
- halt  in  1  freeze all state
- mem_rdata  in  16  instruction word from memory
- datapath_out  in  16  datapath C result
- status  in  3  {N,V,Z} from datapath status register
- ir  out  16  instruction register
- opcode  out  3  ir[15:13]
- op  out  2  ir[12:11]
- reg_num  out  3  selected register number
- sh  out  2  ir[4:3]
- sximm5  out  16  sign-extended ir[4:0]
- sximm8  out  16  sign-extended ir[7:0]
- cond  out  3  ir[10:8]
- pc  out  PC_W  program counter
- mem_addr  out  PC_W  memory address
- branch_taken  out  1  registered one-cycle pulse
- instr_count  out  CNT_W  count of IR loads

Behaviour:
- Reset (reset_n=0, asynchronous)
  - pc=RESET_PC; IR=0; data address register=0; instr_count=0; branch_taken=0.
  - All decoded outputs follow IR=0, so they are 0.
  - Asserting reset mid-operation aborts the operation immediately.
  - The first rising edge after deassertion applies normal rules.
- halt=1: pc, IR, address register and instr_count hold; branch_taken=0. Only reset_n clears the halt freeze.
- PC update priority: halt > reset_pc > load_pc.
  - reset_pc=1: pc<=RESET_PC, regardless of load_pc.
  - load_pc, pc_sel=00: pc<=pc+1.
  - load_pc, pc_sel=01: target = pc + sximm8[PC_W-1:0], using the already-incremented pc. If cond_br=0, or the condition is true, then pc<=target and branch_taken<=1; otherwise pc<=pc+1.
  - load_pc, pc_sel=10: pc<=datapath_out[PC_W-1:0].
  - load_pc, pc_sel=11: pc holds.
  - All PC arithmetic is modulo 2^PC_W, so pc=all-ones plus 1 wraps to 0.
- Branch conditions, cond = ir[10:8]:
  - 000: always
  - 001: Z
  - 010: !Z
  - 011: N!=V
  - 100: (N!=V)|Z
  - 101–111: never taken
- load_ir: IR<=mem_rdata and instr_count<=instr_count+1. instr_count wraps at 2^CNT_W.
- load_ir together with load_pc in the same cycle: both take effect. Branch evaluation uses the old IR and the old status.
- load_addr: address register<=datapath_out[PC_W-1:0].
- mem_addr is combinational: addr_sel ? pc : address register. Latency is zero cycles from addr_sel.
- reg_num is combinational:
  - nsel[2] -> ir[10:8] (Rn)
  - else nsel[1] -> ir[7:5] (Rd)
  - else nsel[0] -> ir[2:0] (Rm)
  - else 000 (covers nsel=000)
  - Priority Rn>Rd>Rm also covers non-one-hot nsel.
- branch_taken is high for exactly the cycle after a taken pc_sel=01 load; it is 0 at all other times.

Decomposition:
- Shared header, fetch_defs: PC_SEL_* codes; COND_* codes; IR field bit positions; nsel one-hot constants. The controller and datapath reuse these.
- One combinational sub-module, branch_cond: inputs cond, status and cond_br; output take.
- All registers live in fetch_unit.

Test Plan:
- Reset then fetch: release reset_n; load_ir with mem_rdata=16'hD105 -> opcode=110, op=10, cond=001, sximm8=16'h0005, instr_count=1; load_pc with pc_sel=00 -> pc=1.
- BEQ: pc=8, IR=16'h21FC (imm8=-4), status Z=1, load_pc with pc_sel=01 and cond_br=1 -> pc=4, branch_taken pulses once. Repeat with Z=0 -> pc=9, branch_taken stays 0.
- BLT/BLE: N=1, V=0 with cond=011 -> taken. N=V, Z=1 with cond=100 -> taken. cond=101 -> pc+1.
- BX and wrap: datapath_out=16'h01FF with pc_sel=10 -> pc=0x1FF; then pc_sel=00 -> pc=0.
- Address path: load_addr with datapath_out=16'h0042, addr_sel=0 -> mem_addr=0x042; addr_sel=1 -> mem_addr=pc. reset_pc together with load_pc -> pc=RESET_PC.
- Halt/async reset: halt=1 with all loads asserted -> no state change. reset_n low mid-cycle -> all outputs 0 immediately, before the next clock edge.
